// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked sequential adder.
// State encoding and a parameter sanity helper.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when CHUNK evenly tiles WIDTH and is in range.
    function automatic bit chunk_ok(input int w, input int c);
        return (c >= 1) && (c <= w) && ((w % c) == 0);
    endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell.
// Building block for the ripple-carry chunk slice.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder.
// Also exposes the carry into its top bit for overflow.
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        fa u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit operands, CHUNK bits per clock.
// Carry is held in a register between chunks; start/done handshake.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    if (!chunk_ok(WIDTH, CHUNK)) begin : g_param_check
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_cout;
    logic             chunk_c_msb;

    assign base    = 32'(idx_q) * 32'(CHUNK);
    assign chunk_a = a_q[base +: CHUNK];
    assign chunk_b = b_q[base +: CHUNK];

    rca_chunk #(
        .CHUNK (CHUNK)
    ) u_rca (
        .a        (chunk_a),
        .b        (chunk_b),
        .cin      (carry_q),
        .s        (chunk_s),
        .cout     (chunk_cout),
        .c_msb_in (chunk_c_msb)
    );

    // Next-state: accept in IDLE/DONE, one chunk per RUN cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d[base +: CHUNK] = chunk_s;
                carry_d = chunk_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    sum_d   = work_d;
                    cout_d  = chunk_cout;
                    ovf_d   = chunk_c_msb ^ chunk_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder with a result scoreboard.
// Covers 16/4 main config plus 8/8 and 8/1 sweeps.
module tb_seq_chunk_adder;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
    } res_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;
    logic        ovf16;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic        busy_w, done_w, cout_w, ovf_w;
    logic [7:0]  sum_w;
    logic        busy_n, done_n, cout_n, ovf_n;
    logic [7:0]  sum_n;

    int errors = 0;
    int checks = 0;
    res_t q16[$];
    res_t q8[$];

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst(rst), .start(start),
        .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16),
        .cout(cout16), .overflow(ovf16)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u8w (
        .clk(clk), .rst(rst), .start(start8),
        .a(a8), .b(b8), .cin(cin8),
        .busy(busy_w), .done(done_w), .sum(sum_w),
        .cout(cout_w), .overflow(ovf_w)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u8n (
        .clk(clk), .rst(rst), .start(start8),
        .a(a8), .b(b8), .cin(cin8),
        .busy(busy_n), .done(done_n), .sum(sum_n),
        .cout(cout_n), .overflow(ovf_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model16(input logic [15:0] x,
                                     input logic [15:0] y,
                                     input logic ci);
        res_t r;
        logic [16:0] t;
        t   = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        r.s = t[15:0];
        r.c = t[16];
        r.v = (x[15] == y[15]) && (t[15] != x[15]);
        return r;
    endfunction

    function automatic res_t model8(input logic [7:0] x,
                                    input logic [7:0] y,
                                    input logic ci);
        res_t r;
        logic [8:0] t;
        t   = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        r.s = {8'd0, t[7:0]};
        r.c = t[8];
        r.v = (x[7] == y[7]) && (t[7] != x[7]);
        return r;
    endfunction

    // Drive a start request this cycle; optionally log the expected result.
    task automatic start16(input logic [15:0] x, input logic [15:0] y,
                           input logic ci, input bit push);
        a16   = x;
        b16   = y;
        cin16 = ci;
        start = 1'b1;
        if (push) q16.push_back(model16(x, y, ci));
    endtask

    task automatic pop16(input string tag);
        res_t e;
        if (q16.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            e = q16.pop_front();
            chk({tag, "_sum"}, 32'(sum16), 32'(e.s));
            chk({tag, "_cout"}, 32'(cout16), 32'(e.c));
            chk({tag, "_ovf"}, 32'(ovf16), 32'(e.v));
        end
    endtask

    // From the start cycle, run until done (bounded) and check the result.
    task automatic finish16(input int lat, input string tag);
        int n;
        step();
        start = 1'b0;
        n = 1;
        while (done16 !== 1'b1 && n < 40) begin
            chk({tag, "_busy"}, 32'(busy16), 32'd1);
            step();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_busy_dn"}, 32'(busy16), 32'd0);
        pop16(tag);
    endtask

    initial begin
        int lw;
        int ln;
        res_t e8;
        rst    = 1'b1;
        start  = 1'b0;
        a16    = '0;
        b16    = '0;
        cin16  = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        cin8   = 1'b0;

        // Reset held three cycles, then idle.
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_done", 32'(done16), 32'd0);
        chk("rst_sum", 32'(sum16), 32'd0);
        chk("rst_cout", 32'(cout16), 32'd0);
        chk("rst_ovf", 32'(ovf16), 32'd0);
        step();
        chk("idle_busy", 32'(busy16), 32'd0);
        chk("idle_done", 32'(done16), 32'd0);

        // Basic add with timing.
        start16(16'h1234, 16'h4321, 1'b0, 1'b1);
        finish16(5, "t2");
        step();
        chk("t2_pulse", 32'(done16), 32'd0);

        // Full carry ripple.
        start16(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        finish16(5, "t3a");
        step();

        // Signed overflow via carry-in.
        start16(16'h7FFF, 16'h0000, 1'b1, 1'b1);
        finish16(5, "t3b");
        step();

        // Ignored start mid-run, then back-to-back from DONE.
        start16(16'h0001, 16'h0002, 1'b0, 1'b1);
        step();
        start = 1'b0;
        step();
        a16   = 16'hAAAA;
        start = 1'b1;
        step();
        start = 1'b0;
        a16   = 16'h0000;
        step();
        step();
        chk("t4_done5", 32'(done16), 32'd1);
        pop16("t4a");
        start16(16'h8000, 16'h8000, 1'b0, 1'b1);
        step();
        start = 1'b0;
        for (int k = 6; k <= 9; k++) begin
            chk("t4_hold", 32'(sum16), 32'h0003);
            chk("t4_busy", 32'(busy16), 32'd1);
            chk("t4_nodone", 32'(done16), 32'd0);
            step();
        end
        chk("t4_done10", 32'(done16), 32'd1);
        pop16("t4b");
        step();

        // Reset mid-run abandons the operation.
        start16(16'h00FF, 16'h0001, 1'b0, 1'b0);
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy", 32'(busy16), 32'd0);
        chk("t5_done", 32'(done16), 32'd0);
        chk("t5_sum", 32'(sum16), 32'd0);
        chk("t5_cout", 32'(cout16), 32'd0);
        chk("t5_ovf", 32'(ovf16), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("t5_nodone", 32'(done16), 32'd0);
            step();
        end
        start16(16'h0010, 16'h0020, 1'b0, 1'b1);
        finish16(5, "t5");
        step();

        // Parameter sweep: CHUNK=WIDTH and CHUNK=1.
        a8     = 8'hC8;
        b8     = 8'h64;
        cin8   = 1'b1;
        start8 = 1'b1;
        q8.push_back(model8(8'hC8, 8'h64, 1'b1));
        step();
        start8 = 1'b0;
        lw = 0;
        ln = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done_w === 1'b1 && lw == 0) lw = k;
            if (done_n === 1'b1 && ln == 0) ln = k;
            step();
        end
        chk("t6_lat_w", 32'(lw), 32'd2);
        chk("t6_lat_n", 32'(ln), 32'd9);
        if (q8.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL t6_sb: observed=empty expected=entry");
        end else begin
            e8 = q8.pop_front();
            chk("t6_sum_w", 32'(sum_w), 32'(e8.s));
            chk("t6_cout_w", 32'(cout_w), 32'(e8.c));
            chk("t6_ovf_w", 32'(ovf_w), 32'(e8.v));
            chk("t6_sum_n", 32'(sum_n), 32'(e8.s));
            chk("t6_cout_n", 32'(cout_n), 32'(e8.c));
            chk("t6_ovf_n", 32'(ovf_n), 32'(e8.v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
